prog_loader: RTL and testbench

- Program writer for the instruction memory: accepts decoded instruction fields over a valid/ready stream and packs each into a 32-bit word {opcode[2:0], fonte[1:0], dest[1:0], imediato[24:0]}.
- Clears memory first, then writes the words to sequential addresses through the memory's Op2 read/write port, optionally reading each word back to verify it.
- Sits in front of mem and is the counterpart of the fetch/decode path, which splits Instruction[31:29], [28:27], [26:25] and [24:0].

---
 rtl/loader_pkg.sv | 40 ++++
 rtl/instr_encoder.sv | 21 ++
 rtl/prog_loader.sv | 134 +++++++++++++
 tb/tb_prog_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants for the program loader: opcodes, instruction field bounds,
// error codes and FSM state encodings.
package loader_pkg;

    // Opcodes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_MCLR = 3'b100;
    localparam logic [2:0] OP_HLT  = 3'b101;
    localparam logic [2:0] OP_MRD  = 3'b110;
    localparam logic [2:0] OP_MWR  = 3'b111;

    // Instruction word field bounds, matching the fetch/decode split
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 29;
    localparam int SRC_HI = 28;
    localparam int SRC_LO = 27;
    localparam int DST_HI = 26;
    localparam int DST_LO = 25;
    localparam int IMM_HI = 24;
    localparam int IMM_LO = 0;

    // Error codes
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_VERIFY = 2'b01;
    localparam logic [1:0] ERR_CAP    = 2'b10;

    // FSM states
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLEAR   = 3'd1;
    localparam logic [2:0] ACCEPT  = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] VERIFY  = 3'd4;
    localparam logic [2:0] ADVANCE = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [2:0] ERR     = 3'd7;

endpackage

// File: rtl/instr_encoder.sv
// Combinational packing of decoded instruction fields into one 32-bit word.
module instr_encoder
    import loader_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [1:0]  fonte,
    input  logic [1:0]  dest,
    input  logic [24:0] imediato,
    output logic [31:0] word
);

    // Place each field at its decode position
    always_comb begin
        word                 = '0;
        word[OPC_HI:OPC_LO]  = opcode;
        word[SRC_HI:SRC_LO]  = fonte;
        word[DST_HI:DST_LO]  = dest;
        word[IMM_HI:IMM_LO]  = imediato;
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: clears instruction memory, then writes a stream of packed
// instructions to sequential addresses, optionally verifying each by read-back.
module prog_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] ADDR_STEP = 32'd1,
    parameter int unsigned MAX_WORDS = 256,
    parameter bit          VERIFY_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_opcode,
    input  logic [1:0]  in_fonte,
    input  logic [1:0]  in_dest,
    input  logic [24:0] in_imm,
    input  logic        in_last,
    output logic        Op2En,
    output logic        Op2RW,
    output logic        M_Clear,
    output logic [31:0] R_W_Addr,
    output logic [31:0] DataWrite,
    input  logic [31:0] DataRead,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [15:0] word_count
);

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_d;
    logic [31:0] data_d;
    logic [15:0] count_d;
    logic [1:0]  error_d;
    logic        last_q, last_d;
    logic [31:0] enc_word;
    logic        cap_hit;

    instr_encoder u_encoder (
        .opcode   (in_opcode),
        .fonte    (in_fonte),
        .dest     (in_dest),
        .imediato (in_imm),
        .word     (enc_word)
    );

    assign in_ready = (state_q == ACCEPT);
    assign cap_hit  = ((32'(word_count) + 32'd1) == 32'(MAX_WORDS));

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        addr_d  = R_W_Addr;
        data_d  = DataWrite;
        count_d = word_count;
        error_d = error;
        last_d  = last_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = CLEAR;
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    error_d = ERR_NONE;
                end
            end
            CLEAR:   state_d = ACCEPT;
            ACCEPT: begin
                if (in_valid) begin
                    data_d  = enc_word;
                    // A halt always ends the program, even without in_last
                    last_d  = in_last | (in_opcode == OP_HLT);
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = VERIFY_EN ? VERIFY : ADVANCE;
            VERIFY: begin
                if (DataRead != DataWrite) begin
                    error_d = ERR_VERIFY;
                    state_d = ERR;
                end else begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                count_d = word_count + 16'd1;
                addr_d  = R_W_Addr + ADDR_STEP;
                if (last_q) begin
                    state_d = DONE;
                end else if (cap_hit) begin
                    error_d = ERR_CAP;
                    state_d = ERR;
                end else begin
                    state_d = ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; strobes decode the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            R_W_Addr   <= BASE_ADDR;
            DataWrite  <= '0;
            word_count <= '0;
            error      <= ERR_NONE;
            last_q     <= 1'b0;
            Op2En      <= 1'b0;
            Op2RW      <= 1'b0;
            M_Clear    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            R_W_Addr   <= addr_d;
            DataWrite  <= data_d;
            word_count <= count_d;
            error      <= error_d;
            last_q     <= last_d;
            Op2En      <= (state_d == WRITE) || (state_d == VERIFY);
            Op2RW      <= (state_d == WRITE);
            M_Clear    <= (state_d == CLEAR);
            busy       <= (state_d == CLEAR) || (state_d == ACCEPT) || (state_d == WRITE) ||
                          (state_d == VERIFY) || (state_d == ADVANCE);
            done       <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: transaction-level model of the load,
// a small memory model on port 2, and a per-cycle write/verify scoreboard.
module tb_prog_loader;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opcode = '0;
    logic [1:0]  in_fonte = '0;
    logic [1:0]  in_dest = '0;
    logic [24:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        Op2En, Op2RW, M_Clear;
    logic [31:0] R_W_Addr, DataWrite, DataRead;
    logic        busy, done;
    logic [1:0]  error;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    prog_loader #(
        .BASE_ADDR (32'd0),
        .ADDR_STEP (32'd1),
        .MAX_WORDS (MAXW),
        .VERIFY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_fonte   (in_fonte),
        .in_dest    (in_dest),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .Op2En      (Op2En),
        .Op2RW      (Op2RW),
        .M_Clear    (M_Clear),
        .R_W_Addr   (R_W_Addr),
        .DataWrite  (DataWrite),
        .DataRead   (DataRead),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    // Memory model; 'corrupt' flips bit 0 of every read
    logic [31:0] mem [16];
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (M_Clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else if (Op2En && Op2RW) begin
            mem[R_W_Addr[3:0]] <= DataWrite;
        end
    end
    assign DataRead = (Op2En && !Op2RW) ? (mem[R_W_Addr[3:0]] ^ {31'd0, corrupt}) : 32'd0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cyc = -1;
    int wr_idx = 0;
    logic done_prev = 1'b0;
    logic [31:0] exp_q [$];

    logic [2:0]  f_op  [8];
    logic [1:0]  f_src [8];
    logic [1:0]  f_dst [8];
    logic [24:0] f_imm [8];
    logic        f_last[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle scoreboard: every write must be the next accepted word at the next address
    always @(negedge clk) begin
        if (rst) begin
            wr_idx = 0;
        end else begin
            if (M_Clear) begin
                chk("clear_excludes_op2", {31'd0, Op2En}, 32'd0);
                wr_idx = 0;
            end
            if (Op2En && Op2RW) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             R_W_Addr, DataWrite);
                end else begin
                    chk("write_addr", R_W_Addr, 32'(wr_idx));
                    chk("write_data", DataWrite, exp_q.pop_front());
                    wr_idx++;
                end
            end
            if (Op2En && !Op2RW) chk("verify_addr", R_W_Addr, 32'(wr_idx - 1));
            chk("ready_implies_busy", {31'd0, in_ready & ~busy}, 32'd0);
            if (done && !done_prev) done_cyc = cyc;
        end
        done_prev = done;
    end

    // One load: model the outcome from the rules, drive the stream, check the result
    task automatic run_load(input int nw, input logic corr, input int stall, input bit stall_rnd,
                            input int rst_word);
        int   n_exp, n_acc, s, budget, st_cyc;
        logic term, fin;
        logic [1:0] e_err;
        logic [31:0] w;

        n_exp = 0;
        term  = 1'b0;
        for (int i = 0; i < nw && !term && n_exp < MAXW; i++) begin
            n_exp++;
            if (f_last[i] || f_op[i] == 3'b101) term = 1'b1;
        end
        if (corr) begin
            n_exp = 1;
            e_err = 2'b01;
        end else begin
            e_err = term ? 2'b00 : 2'b10;
        end

        exp_q.delete();
        corrupt  = corr;
        done_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        st_cyc = cyc;

        n_acc = 0;
        fin   = 1'b0;
        for (int i = 0; i < nw && !fin; i++) begin
            s = stall_rnd ? int'($urandom_range(stall, 0)) : stall;
            in_valid = 1'b0;
            repeat (s) begin
                @(negedge clk);
                if (in_ready) chk("stall_no_strobes", {30'd0, Op2En, M_Clear}, 32'd0);
                @(posedge clk); #1;
            end
            in_opcode = f_op[i];
            in_fonte  = f_src[i];
            in_dest   = f_dst[i];
            in_imm    = f_imm[i];
            in_last   = f_last[i];
            in_valid  = 1'b1;
            budget    = 0;
            while (1) begin
                @(negedge clk);
                if (in_ready) begin
                    @(posedge clk); #1;
                    exp_q.push_back({f_op[i], f_src[i], f_dst[i], f_imm[i]});
                    n_acc++;
                    break;
                end
                if (!busy) begin
                    fin = 1'b1;
                    break;
                end
                budget++;
                if (budget > 40) begin
                    chk("accept_timeout", 32'(budget), 32'd0);
                    fin = 1'b1;
                    break;
                end
            end
            if (!fin && i == rst_word) begin
                // Now in the WRITE cycle of this word
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                in_valid = 1'b0;
                chk("rst_op2en", {31'd0, Op2En}, 32'd0);
                chk("rst_wcount", {16'd0, word_count}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_ready", {31'd0, in_ready}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_error", {30'd0, error}, 32'd0);
                chk("rst_addr", R_W_Addr, 32'd0);
                fin = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;

        budget = 0;
        while (busy && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        chk("finish_timeout", {31'd0, busy}, 32'd0);
        chk("accepted", 32'(n_acc), 32'(n_exp));
        chk("done", {31'd0, done}, {31'd0, e_err == 2'b00});
        chk("error", {30'd0, error}, {30'd0, e_err});
        chk("word_count", {16'd0, word_count}, corr ? 32'd0 : 32'(n_exp));
        chk("ready_after", {31'd0, in_ready}, 32'd0);
        chk("op2en_after", {31'd0, Op2En}, 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 8; k++) begin
            w = (k < n_exp) ? {f_op[k], f_src[k], f_dst[k], f_imm[k]} : 32'd0;
            chk($sformatf("mem[%0d]", k), mem[k], w);
        end
        if (stall == 0 && e_err == 2'b00) chk("latency", 32'(done_cyc - st_cyc), 32'(1 + 4 * n_exp));
        corrupt = 1'b0;
    endtask

    task automatic set_f(input int i, input logic [2:0] op, input logic [1:0] src,
                         input logic [1:0] dst, input logic [24:0] imm, input logic last);
        f_op[i] = op; f_src[i] = src; f_dst[i] = dst; f_imm[i] = imm; f_last[i] = last;
    endtask

    initial begin
        int nw;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op2en", {31'd0, Op2En}, 32'd0);
        chk("rst_op2rw", {31'd0, Op2RW}, 32'd0);
        chk("rst_mclear", {31'd0, M_Clear}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {30'd0, error}, 32'd0);
        chk("rst_wcount", {16'd0, word_count}, 32'd0);
        chk("rst_addr", R_W_Addr, 32'd0);
        chk("rst_wdata", DataWrite, 32'd0);
        rst = 1'b0;

        // Single add
        set_f(0, 3'b000, 2'b01, 2'b10, 25'd5, 1'b1);
        run_load(1, 1'b0, 0, 1'b0, -1);
        chk("add_literal_mem", mem[0], 32'h0C000005);
        chk("add_literal_dw", DataWrite, 32'h0C000005);

        // Halt terminates without in_last; third word never taken
        set_f(0, 3'b000, 2'b01, 2'b10, 25'd7, 1'b0);
        set_f(1, 3'b101, 2'b00, 2'b00, 25'd0, 1'b0);
        set_f(2, 3'b000, 2'b11, 2'b11, 25'd9, 1'b0);
        run_load(3, 1'b0, 0, 1'b0, -1);
        chk("halt_literal0", mem[0], 32'h0C000007);
        chk("halt_literal1", mem[1], 32'hA0000000);

        // Field extremes
        set_f(0, 3'b111, 2'b11, 2'b01, 25'h1FFFFFF, 1'b1);
        run_load(1, 1'b0, 0, 1'b0, -1);
        chk("extreme_literal", DataWrite, 32'hFBFFFFFF);

        // Verify mismatch, then a clean restart
        set_f(0, 3'b011, 2'b10, 2'b01, 25'h12345, 1'b0);
        set_f(1, 3'b000, 2'b00, 2'b00, 25'd1, 1'b1);
        run_load(2, 1'b1, 0, 1'b0, -1);
        set_f(0, 3'b000, 2'b01, 2'b10, 25'd5, 1'b1);
        run_load(1, 1'b0, 0, 1'b0, -1);

        // Capacity: five words, no terminator
        for (int i = 0; i < 5; i++) set_f(i, 3'b001, 2'(i), 2'(i + 1), 25'(i * 3 + 1), 1'b0);
        run_load(5, 1'b0, 0, 1'b0, -1);

        // Reset in WRITE of word 2, then a load with 3-cycle stalls
        for (int i = 0; i < 3; i++) set_f(i, 3'b010, 2'b01, 2'b01, 25'(100 + i), 1'b0);
        run_load(3, 1'b0, 0, 1'b0, 1);
        f_last[2] = 1'b1;
        run_load(3, 1'b0, 3, 1'b0, -1);

        // Randomized loads
        for (int t = 0; t < 40; t++) begin
            nw = int'($urandom_range(6, 1));
            for (int i = 0; i < nw; i++) begin
                set_f(i, 3'($urandom_range(7, 0)), 2'($urandom), 2'($urandom), 25'($urandom),
                      ($urandom_range(7, 0) == 0));
            end
            if (nw <= MAXW) f_last[nw - 1] = 1'b1;
            run_load(nw, ($urandom_range(4, 0) == 0), int'($urandom_range(2, 0)), 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
